det_sec_param: RTL and testbench
================================

# det_sec_param

Parametrised serial sequence detector, the next generation of the fixed-pattern `det_sec`. It watches a qualified serial bit stream for a runtime-loadable pattern of `PAT_W` bits, with selectable overlapping or non-overlapping detection. On each detection it issues a one-cycle `valido` pulse and increments a saturating match counter. It sits on the serial receive path in place of `det_sec` and is driven by the same kind of bit-level stimulus generator.

## Interface
- `PAT_W`, 4, pattern length in bits (legal 2..32).
- `PATRON_RST`, 4'b1101, pattern loaded at reset (`PAT_W` bits; first-received bit is the MSB).
- `SOLAPA_RST`, 1, overlap mode at reset (1 = overlapping, 0 = non-overlapping).
- `CNT_W`, 8, width of the match counter.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `s_in`  in  1  serial data bit.
- `s_en`  in  1  bit qualifier; `s_in` is sampled only when 1.
- `cfg_ld`  in  1  load `cfg_patron` and `cfg_solapa`; clears detection history.
- `cfg_patron`  in  `PAT_W`  new pattern, first bit = MSB.
- `cfg_solapa`  in  1  new overlap mode, captured on `cfg_ld`.
- `cuenta_clr`  in  1  clear the match counter and the saturation flag.
- `valido`  out  1  registered one-cycle match pulse.
- `cuenta`  out  `CNT_W`  number of matches, saturating.
- `satur`  out  1  sticky flag: counter reached its maximum value.

## Operation
- State: `patron` (`PAT_W` bits), `solapa`, `ventana` (last `PAT_W-1` accepted bits), `llenos` (0..`PAT_W-1`, number of valid history bits), `cuenta`, `satur`, `valido`.
- Reset (`rst`=1): `patron`=`PATRON_RST`, `solapa`=`SOLAPA_RST`, `ventana`=0, `llenos`=0, `cuenta`=0, `satur`=0, `valido`=0. Reset overrides every other input.
- Per-cycle priority is `rst` > `cfg_ld` > `s_en`. `cuenta_clr` is handled independently; see Counter.
- `cfg_ld`=1:
  - `patron`<=`cfg_patron` and `solapa`<=`cfg_solapa`.
  - `llenos`<=0 and `valido`<=0.
  - `s_in` is ignored that cycle, even if `s_en`=1.
- Accepted bit (`s_en`=1, no `cfg_ld`):
  - Candidate window: `cand` = {`ventana`, `s_in`}.
  - Match: `llenos`==`PAT_W-1` and `cand`==`patron`.
  - `ventana` shifts left by one, taking in `s_in`.
  - Without a match, `llenos` increments and saturates at `PAT_W-1`.
  - On a match in overlap mode, `llenos` stays at `PAT_W-1`, so the trailing bits can start the next match.
  - On a match in non-overlap mode, `llenos`<=0, so the next match needs `PAT_W` fresh bits.
- `valido`<=match. `valido` is 0 in any cycle with `s_en`=0.
- Idle cycles (`s_en`=0) hold all history. Gaps do not break a partial sequence.
- Counter:
  - On a match, `cuenta` increments, unless it is already at 2^`CNT_W`-1, where it holds.
  - `satur`<=1 on the cycle `cuenta` becomes the maximum value. `satur` stays 1 until `cuenta_clr` or `rst`.
  - `cuenta_clr`=1 forces `cuenta`<=0 and `satur`<=0. A match in the same cycle still pulses `valido` but is not counted.

## Timing
- Latency: `valido` goes high in the cycle after the rising edge that samples the completing bit, for exactly one cycle.
- Back-to-back matches are possible in overlap mode, giving `valido` high on consecutive cycles (pattern 1111, input 11111).
- `cuenta` updates on the same edge that raises `valido`.
- A new pattern from `cfg_ld` is effective for the first accepted bit after the load edge. The earliest possible match is `PAT_W` accepted bits later.
- If reset is applied mid-sequence, the partial sequence is lost. The earliest match after reset is release plus `PAT_W` accepted bits.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Overlap: default parameters, `s_en`=1, stream 1,1,0,1,1,0,1 -> `valido` pulses after bits 4 and 7; `cuenta`=2.
- Non-overlap: `cfg_ld` with `cfg_patron`=1101, `cfg_solapa`=0, then the same stream -> single pulse after bit 4; `cuenta`=1.
- Gaps: stream 1,1 then `s_en`=0 for 5 cycles, then 0,1 -> one pulse after the final bit; `valido` stays low during the gap.
- Reset mid-stream: bits 1,1,0, then `rst` for 1 cycle, then bit 1 -> no pulse; `cuenta`=0 and all outputs 0 during and after reset.
- Saturation and clear:
  - `CNT_W`=2, 4 overlap matches of 1101 -> `cuenta`=3 and `satur`=1 after the third match; both hold after the fourth.
  - `cuenta_clr` asserted together with a match -> `valido`=1, `cuenta`=0, `satur`=0.
- Reload mid-stream: after bits 1,1,0, `cfg_ld` with 0110 (bit ignored), then 0,1,1,0 -> one pulse after the last 0; the old pattern 1101 is not detected.

Source files
------------

// File: rtl/det_sec_param.sv
// rtl/det_sec_param.sv - runtime-loadable serial pattern detector with saturating match counter
// Overlap mode keeps the history full after a match; non-overlap restarts the fill count.
module det_sec_param #(
  parameter int               PAT_W      = 4,
  parameter logic [PAT_W-1:0] PATRON_RST = 4'b1101,
  parameter logic             SOLAPA_RST = 1'b1,
  parameter int               CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_in,
  input  logic             s_en,
  input  logic             cfg_ld,
  input  logic [PAT_W-1:0] cfg_patron,
  input  logic             cfg_solapa,
  input  logic             cuenta_clr,
  output logic             valido,
  output logic [CNT_W-1:0] cuenta,
  output logic             satur
);

  localparam int               LW        = $clog2(PAT_W);
  localparam logic [LW-1:0]    LLENO_MAX = LW'(PAT_W - 1);
  localparam logic [LW-1:0]    LLENO_ONE = LW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [PAT_W-1:0] patron_q, patron_d;
  logic             solapa_q, solapa_d;
  logic [PAT_W-2:0] ventana_q, ventana_d;
  logic [LW-1:0]    llenos_q, llenos_d;
  logic [CNT_W-1:0] cuenta_q, cuenta_d;
  logic             satur_q, satur_d;
  logic             valido_q, valido_d;

  logic [PAT_W-1:0] cand;
  logic             acepta;
  logic             match;

  assign cand   = {ventana_q, s_in};
  assign acepta = s_en && !cfg_ld;
  assign match  = acepta && (llenos_q == LLENO_MAX) && (cand == patron_q);

  always_comb begin
    patron_d  = patron_q;
    solapa_d  = solapa_q;
    ventana_d = ventana_q;
    llenos_d  = llenos_q;
    valido_d  = match;

    if (cfg_ld) begin
      patron_d = cfg_patron;
      solapa_d = cfg_solapa;
      llenos_d = '0;
    end else if (s_en) begin
      ventana_d = cand[PAT_W-2:0];
      if (match) begin
        llenos_d = solapa_q ? LLENO_MAX : '0;
      end else if (llenos_q != LLENO_MAX) begin
        llenos_d = llenos_q + LLENO_ONE;
      end
    end
  end

  // A clear wins over a simultaneous match: the pulse still fires but is not counted.
  always_comb begin
    cuenta_d = cuenta_q;
    satur_d  = satur_q;
    if (cuenta_clr) begin
      cuenta_d = '0;
      satur_d  = 1'b0;
    end else if (match && (cuenta_q != CNT_MAX)) begin
      cuenta_d = cuenta_q + CNT_ONE;
      if (cuenta_d == CNT_MAX) begin
        satur_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      patron_q  <= PATRON_RST;
      solapa_q  <= SOLAPA_RST;
      ventana_q <= '0;
      llenos_q  <= '0;
      cuenta_q  <= '0;
      satur_q   <= 1'b0;
      valido_q  <= 1'b0;
    end else begin
      patron_q  <= patron_d;
      solapa_q  <= solapa_d;
      ventana_q <= ventana_d;
      llenos_q  <= llenos_d;
      cuenta_q  <= cuenta_d;
      satur_q   <= satur_d;
      valido_q  <= valido_d;
    end
  end

  assign valido = valido_q;
  assign cuenta = cuenta_q;
  assign satur  = satur_q;

endmodule

// File: tb/tb_det_sec_param.sv
// tb/tb_det_sec_param.sv - directed bench for det_sec_param with a 2-bit counter
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_det_sec_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_in = 1'b0;
  logic       s_en = 1'b0;
  logic       cfg_ld = 1'b0;
  logic [3:0] cfg_patron = 4'b0000;
  logic       cfg_solapa = 1'b0;
  logic       cuenta_clr = 1'b0;
  logic       valido;
  logic [1:0] cuenta;
  logic       satur;

  int checks = 0;
  int errors = 0;

  det_sec_param #(
    .PAT_W(4), .PATRON_RST(4'b1101), .SOLAPA_RST(1'b1), .CNT_W(2)
  ) dut (
    .clk(clk), .rst(rst), .s_in(s_in), .s_en(s_en), .cfg_ld(cfg_ld),
    .cfg_patron(cfg_patron), .cfg_solapa(cfg_solapa), .cuenta_clr(cuenta_clr),
    .valido(valido), .cuenta(cuenta), .satur(satur)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b, input logic exp_v, input string tag);
    s_in = b;
    s_en = 1'b1;
    tick();
    chk(tag, {31'b0, valido}, {31'b0, exp_v});
  endtask

  task automatic idle(input int n);
    s_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      chk("idle_valido", {31'b0, valido}, 32'd0);
    end
  endtask

  task automatic load(input logic [3:0] p, input logic sol);
    cfg_ld = 1'b1; cfg_patron = p; cfg_solapa = sol;
    s_en = 1'b1; s_in = 1'b1;
    tick();
    chk("load_valido", {31'b0, valido}, 32'd0);
    cfg_ld = 1'b0; s_en = 1'b0;
  endtask

  task automatic clear();
    s_en = 1'b0; cuenta_clr = 1'b1;
    tick();
    cuenta_clr = 1'b0;
    chk("clr_cuenta", {30'b0, cuenta}, 32'd0);
    chk("clr_satur", {31'b0, satur}, 32'd0);
  endtask

  initial begin
    #1;
    tick();
    tick();
    chk("rst_valido", {31'b0, valido}, 32'd0);
    chk("rst_cuenta", {30'b0, cuenta}, 32'd0);
    chk("rst_satur", {31'b0, satur}, 32'd0);
    rst = 1'b0;

    // Overlap with reset pattern 1101
    send(1, 0, "ov_b1"); send(1, 0, "ov_b2"); send(0, 0, "ov_b3"); send(1, 1, "ov_b4");
    send(1, 0, "ov_b5"); send(0, 0, "ov_b6"); send(1, 1, "ov_b7");
    chk("ov_cuenta", {30'b0, cuenta}, 32'd2);
    chk("ov_satur", {31'b0, satur}, 32'd0);
    idle(1);

    // Non-overlap
    clear();
    load(4'b1101, 1'b0);
    send(1, 0, "no_b1"); send(1, 0, "no_b2"); send(0, 0, "no_b3"); send(1, 1, "no_b4");
    send(1, 0, "no_b5"); send(0, 0, "no_b6"); send(1, 0, "no_b7");
    chk("no_cuenta", {30'b0, cuenta}, 32'd1);

    // Gaps hold the partial sequence
    clear();
    load(4'b1101, 1'b1);
    send(1, 0, "gap_b1"); send(1, 0, "gap_b2");
    idle(5);
    send(0, 0, "gap_b3"); send(1, 1, "gap_b4");
    chk("gap_cuenta", {30'b0, cuenta}, 32'd1);

    // Reset mid-stream loses history and counter
    send(1, 0, "rm_b1"); send(1, 0, "rm_b2"); send(0, 0, "rm_b3");
    s_en = 1'b0; rst = 1'b1;
    tick();
    chk("rm_rst_valido", {31'b0, valido}, 32'd0);
    chk("rm_rst_cuenta", {30'b0, cuenta}, 32'd0);
    chk("rm_rst_satur", {31'b0, satur}, 32'd0);
    rst = 1'b0;
    send(1, 0, "rm_b4");
    chk("rm_cuenta", {30'b0, cuenta}, 32'd0);
    idle(1);

    // Saturation: reset defaults (overlap) and 2-bit counter; rm_b4 already filled 1 bit
    send(1, 0, "sat_b2"); send(0, 0, "sat_b3"); send(1, 1, "sat_m1");
    send(1, 0, "sat_b5"); send(0, 0, "sat_b6"); send(1, 1, "sat_m2");
    chk("sat_cuenta_m2", {30'b0, cuenta}, 32'd2);
    chk("sat_satur_m2", {31'b0, satur}, 32'd0);
    send(1, 0, "sat_b8"); send(0, 0, "sat_b9"); send(1, 1, "sat_m3");
    chk("sat_cuenta_m3", {30'b0, cuenta}, 32'd3);
    chk("sat_satur_m3", {31'b0, satur}, 32'd1);
    send(1, 0, "sat_b11"); send(0, 0, "sat_b12"); send(1, 1, "sat_m4");
    chk("sat_cuenta_m4", {30'b0, cuenta}, 32'd3);
    chk("sat_satur_m4", {31'b0, satur}, 32'd1);

    // Clear coinciding with a match
    send(1, 0, "cm_b1"); send(0, 0, "cm_b2");
    cuenta_clr = 1'b1;
    send(1, 1, "cm_match");
    cuenta_clr = 1'b0;
    chk("cm_cuenta", {30'b0, cuenta}, 32'd0);
    chk("cm_satur", {31'b0, satur}, 32'd0);

    // Reload mid-stream to 0110
    send(1, 0, "rl_b1"); send(1, 0, "rl_b2"); send(0, 0, "rl_b3");
    load(4'b0110, 1'b1);
    send(0, 0, "rl_b4"); send(1, 0, "rl_b5"); send(1, 0, "rl_b6"); send(0, 1, "rl_b7");
    send(1, 0, "rl_old");
    chk("rl_cuenta", {30'b0, cuenta}, 32'd1);
    idle(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
